decode_id: RTL and testbench

Instruction-decode stage of the five-stage pipeline. It consumes the fetch stage's IF/ID outputs (`if_id_instr`, `if_id_npc`) and decodes the MIPS-subset instruction. It reads the 32×32 register file, which the write-back stage writes, and sign-extends the immediate. All results are registered into the ID/EX latch. It also accepts the EX/MEM redirect (`ex_mem_pc_src`) that fetch consumes, and uses it to squash the instruction in decode.

---
 rtl/pipe_pkg.sv | 83 ++++++++
 rtl/regfile.sv | 68 ++++++
 rtl/decode_id.sv | 113 +++++++++++
 tb/tb_decode_id.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline stages: opcode constants, widths of the
// three control bundles carried down the pipe (wb / m / ex), the bit position
// of every control signal inside those bundles, the ALUOp encodings, and a
// helper that turns an opcode into its control bundle.
// ---------------------------------------------------------------------------
package pipe_pkg;

   // Opcodes of the supported MIPS subset
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // Control bundle widths
   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   // wb = {RegWrite, MemtoReg}
   localparam int WB_REG_WRITE  = 1;
   localparam int WB_MEM_TO_REG = 0;

   // m = {Branch, MemRead, MemWrite}
   localparam int M_BRANCH    = 2;
   localparam int M_MEM_READ  = 1;
   localparam int M_MEM_WRITE = 0;

   // ex = {RegDst, ALUOp[1:0], ALUSrc}
   localparam int EX_REG_DST   = 3;
   localparam int EX_ALU_OP_HI = 2;
   localparam int EX_ALU_OP_LO = 1;
   localparam int EX_ALU_SRC   = 0;

   // ALUOp tells the EX stage whether to add (address), subtract (compare)
   // or look at the funct field (R-type)
   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic [WB_W-1:0] wb;
      logic [M_W-1:0]  m;
      logic [EX_W-1:0] ex;
   } ctrl_t;

   // Any opcode outside the subset decodes to an all-zero bundle, which the
   // later stages treat as a bubble.
   function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
      ctrl_t c;
      c = '0;
      case (opcode)
         OP_RTYPE: begin
            c.wb[WB_REG_WRITE]                = 1'b1;
            c.ex[EX_REG_DST]                  = 1'b1;
            c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALU_OP_FUNCT;
         end
         OP_LW: begin
            c.wb[WB_REG_WRITE]                = 1'b1;
            c.wb[WB_MEM_TO_REG]               = 1'b1;
            c.m[M_MEM_READ]                   = 1'b1;
            c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALU_OP_ADD;
            c.ex[EX_ALU_SRC]                  = 1'b1;
         end
         OP_SW: begin
            c.m[M_MEM_WRITE]                  = 1'b1;
            c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALU_OP_ADD;
            c.ex[EX_ALU_SRC]                  = 1'b1;
         end
         OP_BEQ: begin
            c.m[M_BRANCH]                     = 1'b1;
            c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALU_OP_SUB;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile
// NREG x W register file with two combinational read ports and one write
// port that is synchronous to clk. Register 0 is hard-wired to zero. A write
// in progress is bypassed to the read ports so decode sees the value
// write-back is producing in the same cycle.
//
// Ports:
//   clk            clock, writes on rising edge
//   rst            asynchronous active-low clear of every register
//   ra1, ra2       read addresses (rs, rt)
//   rd1, rd2       read data
//   we, wa, wd     write enable / address / data
// ---------------------------------------------------------------------------
module regfile #(
   parameter int NREG = 32,
   parameter int W    = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   ra1,
   input  logic [4:0]   ra2,
   output logic [W-1:0] rd1,
   output logic [W-1:0] rd2,
   input  logic         we,
   input  logic [4:0]   wa,
   input  logic [W-1:0] wd
);

   logic [W-1:0] regs [NREG];
   logic         write_en;

   // Writes aimed at register 0 are dropped here, so the bypass below also
   // never forwards them.
   assign write_en = we && (wa != 5'd0);

   // Storage: cleared by reset, otherwise one write per edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[wa] <= wd;
      end
   end

   // Read ports: zero register first, then same-cycle write bypass, then array
   always_comb begin
      if (ra1 == 5'd0) begin
         rd1 = '0;
      end else if (write_en && (wa == ra1)) begin
         rd1 = wd;
      end else begin
         rd1 = regs[ra1];
      end

      if (ra2 == 5'd0) begin
         rd2 = '0;
      end else if (write_en && (wa == ra2)) begin
         rd2 = wd;
      end else begin
         rd2 = regs[ra2];
      end
   end

endmodule

// File: rtl/decode_id.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// decode_id
// Instruction-decode stage. Splits the IF/ID instruction into fields,
// decodes control, reads rs/rt from the register file (written by
// write-back), sign-extends the immediate and registers everything into the
// ID/EX latch. A taken-branch redirect from EX/MEM turns the slot into a
// bubble by zeroing the control fields only.
//
// Ports:
//   clk, rst                        clock, async active-low reset
//   if_id_instr, if_id_npc          IF/ID latch contents
//   ex_mem_pc_src                   redirect, squashes the decode slot
//   wb_reg_write/write_reg/data     register-file write port
//   id_ex_wb, id_ex_m, id_ex_ex     registered control bundles
//   id_ex_npc, id_ex_rd1/rd2        registered PC+4 and operands
//   id_ex_imm, id_ex_rt, id_ex_rd   registered immediate and dest fields
// ---------------------------------------------------------------------------
module decode_id
   import pipe_pkg::*;
#(
   parameter int NREG = 32,
   parameter int W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     if_id_instr,
   input  logic [31:0]     if_id_npc,
   input  logic            ex_mem_pc_src,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_write_reg,
   input  logic [W-1:0]    wb_write_data,
   output logic [WB_W-1:0] id_ex_wb,
   output logic [M_W-1:0]  id_ex_m,
   output logic [EX_W-1:0] id_ex_ex,
   output logic [31:0]     id_ex_npc,
   output logic [W-1:0]    id_ex_rd1,
   output logic [W-1:0]    id_ex_rd2,
   output logic [W-1:0]    id_ex_imm,
   output logic [4:0]      id_ex_rt,
   output logic [4:0]      id_ex_rd
);

   logic [5:0]   opcode;
   logic [4:0]   rs;
   logic [4:0]   rt;
   logic [4:0]   rd;
   logic [15:0]  imm;
   ctrl_t        ctrl;
   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic [W-1:0] imm_ext;

   assign opcode = if_id_instr[31:26];
   assign rs     = if_id_instr[25:21];
   assign rt     = if_id_instr[20:16];
   assign rd     = if_id_instr[15:11];
   assign imm    = if_id_instr[15:0];

   regfile #(
      .NREG (NREG),
      .W    (W)
   ) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rs_val),
      .rd2 (rt_val),
      .we  (wb_reg_write),
      .wa  (wb_write_reg),
      .wd  (wb_write_data)
   );

   // Control decode and sign extension of the 16-bit immediate
   always_comb begin
      ctrl    = decode_ctrl(opcode);
      imm_ext = {{(W-16){imm[15]}}, imm};
   end

   // ID/EX latch: loads every cycle; a redirect only blanks the control
   // bundles, the data fields are don't-care for a bubble and load anyway
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_ex_wb  <= '0;
         id_ex_m   <= '0;
         id_ex_ex  <= '0;
         id_ex_npc <= '0;
         id_ex_rd1 <= '0;
         id_ex_rd2 <= '0;
         id_ex_imm <= '0;
         id_ex_rt  <= '0;
         id_ex_rd  <= '0;
      end else begin
         if (ex_mem_pc_src) begin
            id_ex_wb <= '0;
            id_ex_m  <= '0;
            id_ex_ex <= '0;
         end else begin
            id_ex_wb <= ctrl.wb;
            id_ex_m  <= ctrl.m;
            id_ex_ex <= ctrl.ex;
         end
         id_ex_npc <= if_id_npc;
         id_ex_rd1 <= rs_val;
         id_ex_rd2 <= rt_val;
         id_ex_imm <= imm_ext;
         id_ex_rt  <= rt;
         id_ex_rd  <= rd;
      end
   end

endmodule

// File: tb/tb_decode_id.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_decode_id
// Directed vectors for the decode stage. Each vector drives one cycle of
// IF/ID and write-back inputs and queues the hand-computed ID/EX contents
// expected after the following rising edge; an independent monitor pops the
// queue just after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_decode_id;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic        ex_mem_pc_src;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic [1:0]  id_ex_wb;
   logic [2:0]  id_ex_m;
   logic [3:0]  id_ex_ex;
   logic [31:0] id_ex_npc;
   logic [31:0] id_ex_rd1;
   logic [31:0] id_ex_rd2;
   logic [31:0] id_ex_imm;
   logic [4:0]  id_ex_rt;
   logic [4:0]  id_ex_rd;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   decode_id #(
      .NREG (32),
      .W    (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_id_instr   (if_id_instr),
      .if_id_npc     (if_id_npc),
      .ex_mem_pc_src (ex_mem_pc_src),
      .wb_reg_write  (wb_reg_write),
      .wb_write_reg  (wb_write_reg),
      .wb_write_data (wb_write_data),
      .id_ex_wb      (id_ex_wb),
      .id_ex_m       (id_ex_m),
      .id_ex_ex      (id_ex_ex),
      .id_ex_npc     (id_ex_npc),
      .id_ex_rd1     (id_ex_rd1),
      .id_ex_rd2     (id_ex_rd2),
      .id_ex_imm     (id_ex_imm),
      .id_ex_rt      (id_ex_rt),
      .id_ex_rd      (id_ex_rd)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single field comparison, shared by the monitor and the reset checks
   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkField("wb",  {30'd0, id_ex_wb}, {30'd0, e.wb});
      checkField("m",   {29'd0, id_ex_m},  {29'd0, e.m});
      checkField("ex",  {28'd0, id_ex_ex}, {28'd0, e.ex});
      checkField("npc", id_ex_npc, e.npc);
      checkField("rd1", id_ex_rd1, e.rd1);
      checkField("rd2", id_ex_rd2, e.rd2);
      checkField("imm", id_ex_imm, e.imm);
      checkField("rt",  {27'd0, id_ex_rt}, {27'd0, e.rt});
      checkField("rd",  {27'd0, id_ex_rd}, {27'd0, e.rd});
   endtask

   task automatic checkAllZero(input string tag);
      checkField({tag, "_wb"},  {30'd0, id_ex_wb}, 32'd0);
      checkField({tag, "_m"},   {29'd0, id_ex_m},  32'd0);
      checkField({tag, "_ex"},  {28'd0, id_ex_ex}, 32'd0);
      checkField({tag, "_npc"}, id_ex_npc, 32'd0);
      checkField({tag, "_rd1"}, id_ex_rd1, 32'd0);
      checkField({tag, "_rd2"}, id_ex_rd2, 32'd0);
      checkField({tag, "_imm"}, id_ex_imm, 32'd0);
      checkField({tag, "_rt"},  {27'd0, id_ex_rt}, 32'd0);
      checkField({tag, "_rd"},  {27'd0, id_ex_rd}, 32'd0);
   endtask

   function automatic exp_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                               input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
      exp_t e;
      e.wb = wb; e.m = m; e.ex = ex; e.npc = npc;
      e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.rt = rt; e.rd = rd;
      return e;
   endfunction

   // Drive one cycle of inputs at the falling edge and queue what the
   // following rising edge must latch
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] npc, input logic pcSrc,
                                input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                                input exp_t e);
      @(negedge clk);
      if_id_instr   = instr;
      if_id_npc     = npc;
      ex_mem_pc_src = pcSrc;
      wb_reg_write  = we;
      wb_write_reg  = wreg;
      wb_write_data = wdata;
      expQ.push_back(e);
   endtask

   task automatic idleInputs();
      @(negedge clk);
      ex_mem_pc_src = 1'b0;
      wb_reg_write  = 1'b0;
   endtask

   task automatic drainQueue();
      int cycles;
      cycles = 0;
      while (expQ.size() != 0 && cycles < 100) begin
         @(posedge clk);
         cycles++;
      end
      #2;
      if (expQ.size() != 0) begin
         bad++;
         total++;
         $display("[TB] FAIL drain actual=%0d required=0 entries left", expQ.size());
      end
   endtask

   // Monitor: one queued expectation per rising edge while out of reset
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst && expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      rst           = 1'b0;
      if_id_instr   = 32'd0;
      if_id_npc     = 32'd0;
      ex_mem_pc_src = 1'b0;
      wb_reg_write  = 1'b0;
      wb_write_reg  = 5'd0;
      wb_write_data = 32'd0;

      repeat (3) @(posedge clk);
      #2;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b1;

      // r1 = 5 while an unknown opcode sits in decode
      applyStimulus(32'hFC00_0000, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5,
                    mk(2'b00, 3'b000, 4'b0000, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0));
      // r2 = 7
      applyStimulus(32'hFC00_0000, 32'h4, 1'b0, 1'b1, 5'd2, 32'd7,
                    mk(2'b00, 3'b000, 4'b0000, 32'h4, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0));
      // add r3,r1,r2
      applyStimulus(32'h0022_1820, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b10, 3'b000, 4'b1100, 32'h8, 32'd5, 32'd7, 32'h0000_1820, 5'd2, 5'd3));
      // lw r4,-4(r1)
      applyStimulus(32'h8C24_FFFC, 32'hC, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b11, 3'b010, 4'b0001, 32'hC, 32'd5, 32'd0, 32'hFFFF_FFFC, 5'd4, 5'd31));
      // add r3,r1,r0 with r1 written in the same cycle: bypass
      applyStimulus(32'h0020_1820, 32'h10, 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF,
                    mk(2'b10, 3'b000, 4'b1100, 32'h10, 32'hDEAD_BEEF, 32'd0, 32'h0000_1820, 5'd0, 5'd3));
      // write to r0 while reading r0 on both ports
      applyStimulus(32'h0000_1820, 32'h14, 1'b0, 1'b1, 5'd0, 32'h1234,
                    mk(2'b10, 3'b000, 4'b1100, 32'h14, 32'd0, 32'd0, 32'h0000_1820, 5'd0, 5'd3));
      // beq squashed, concurrent write r5 = 0xA5A5
      applyStimulus(32'h1022_0003, 32'h18, 1'b1, 1'b1, 5'd5, 32'h0000_A5A5,
                    mk(2'b00, 3'b000, 4'b0000, 32'h18, 32'hDEAD_BEEF, 32'd7, 32'd3, 5'd2, 5'd0));
      // same beq, not squashed
      applyStimulus(32'h1022_0003, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b00, 3'b100, 4'b0010, 32'h1C, 32'hDEAD_BEEF, 32'd7, 32'd3, 5'd2, 5'd0));
      // add r6,r0,r5: squashed-cycle write landed, r0 still zero
      applyStimulus(32'h0005_3020, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b10, 3'b000, 4'b1100, 32'h20, 32'd0, 32'h0000_A5A5, 32'h0000_3020, 5'd5, 5'd6));
      // sw r4,8(r1)
      applyStimulus(32'hAC24_0008, 32'h24, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b00, 3'b001, 4'b0001, 32'h24, 32'hDEAD_BEEF, 32'd0, 32'd8, 5'd4, 5'd0));
      // opcode 111111 with real register fields
      applyStimulus(32'hFC22_1820, 32'h28, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b00, 3'b000, 4'b0000, 32'h28, 32'hDEAD_BEEF, 32'd7, 32'h0000_1820, 5'd2, 5'd3));
      // lw with largest positive offset: no sign extension
      applyStimulus(32'h8C24_7FFF, 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b11, 3'b010, 4'b0001, 32'h2C, 32'hDEAD_BEEF, 32'd0, 32'h0000_7FFF, 5'd4, 5'd15));
      // add r3,r1,r2 so the latch holds nonzero values before the reset
      applyStimulus(32'h0022_1820, 32'h30, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b10, 3'b000, 4'b1100, 32'h30, 32'hDEAD_BEEF, 32'd7, 32'h0000_1820, 5'd2, 5'd3));
      idleInputs();
      drainQueue();

      // Mid-run reset between edges must clear the outputs immediately
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkAllZero("async_rst");
      @(negedge clk);
      rst = 1'b1;

      // Registers were cleared along with the latch
      applyStimulus(32'h0022_1820, 32'h34, 1'b0, 1'b0, 5'd0, 32'd0,
                    mk(2'b10, 3'b000, 4'b1100, 32'h34, 32'd0, 32'd0, 32'h0000_1820, 5'd2, 5'd3));
      idleInputs();
      drainQueue();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop if something above stalls
   initial begin
      #100000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
